// File: rtl/perip_bridge_if.sv
// Core-to-peripheral bus: one access per cycle, reads return one cycle after the address.
interface perip_bridge_if;
    // No valid/ready: the bridge is always ready, a write commits at the edge where
    // perip_wen=1, and every cycle's address yields perip_rdata after the following edge.
    logic [31:0] perip_addr;
    logic        perip_wen;
    logic [1:0]  perip_mask;
    logic [31:0] perip_wdata;
    logic [31:0] perip_rdata;

    modport master (
        output perip_addr, perip_wen, perip_mask, perip_wdata,
        input  perip_rdata
    );

    modport slave (
        input  perip_addr, perip_wen, perip_mask, perip_wdata,
        output perip_rdata
    );
endinterface

// File: rtl/perip_bridge.sv
// Peripheral bridge: DRAM, LED register, buffered 8N1 UART transmitter and 64-bit cycle counter.
module perip_bridge #(
    parameter int unsigned DRAM_AW    = 14,
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned FIFO_DEPTH = 8,
    // Value the cycle counter takes under reset; lets carry boundaries be reached quickly.
    parameter logic [63:0] CNT_INIT   = 64'h0
) (
    input  logic                 clk,
    input  logic                 rst,
    perip_bridge_if.slave        bus,
    output logic                 uart_tx,
    output logic [15:0]          led,
    output logic [1:0]           dbg_uart_state
);
    localparam logic [31:0] DRAM_BASE  = 32'h8010_0000;
    localparam logic [31:0] DRAM_BYTES = 32'(4) << DRAM_AW;
    localparam logic [31:0] DRAM_END   = DRAM_BASE + DRAM_BYTES;
    localparam logic [29:0] WA_LED     = 30'h2008_0000;
    localparam logic [29:0] WA_UDATA   = 30'h2008_0004;
    localparam logic [29:0] WA_USTAT   = 30'h2008_0005;
    localparam logic [29:0] WA_CNT_LO  = 30'h2008_0008;
    localparam logic [29:0] WA_CNT_HI  = 30'h2008_0009;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_CNT = BW'(CLK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    logic [29:0]        word_addr;
    logic               dram_hit;
    logic [DRAM_AW-1:0] dram_idx;
    logic [3:0]         be;
    logic [31:0]        wlane;
    logic [31:0]        dram [2**DRAM_AW];

    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic               fifo_full, fifo_empty, push, push_ok, pop;

    uart_state_t        state, state_nx;
    logic [BW-1:0]      baud_cnt, baud_nx;
    logic [2:0]         bit_idx, bit_nx;
    logic [7:0]         shreg, sh_nx;
    logic               last_tick;

    logic [63:0]        cnt;
    logic [31:0]        shadow;
    logic [31:0]        stat;
    logic [31:0]        rd_nx;

    assign word_addr = bus.perip_addr[31:2];
    assign dram_hit  = (bus.perip_addr >= DRAM_BASE) && (bus.perip_addr < DRAM_END);
    assign dram_idx  = bus.perip_addr[DRAM_AW+1:2];

    // Replicate the LSB-aligned data across lanes so each enabled lane picks its own copy.
    always_comb begin
        be    = 4'b1111;
        wlane = bus.perip_wdata;
        case (bus.perip_mask)
            2'b00: begin
                be    = 4'b0001 << bus.perip_addr[1:0];
                wlane = {4{bus.perip_wdata[7:0]}};
            end
            2'b01: begin
                be    = bus.perip_addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{bus.perip_wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = bus.perip_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (bus.perip_wen && dram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) dram[dram_idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led <= 16'h0;
        end else if (bus.perip_wen && !dram_hit && word_addr == WA_LED) begin
            if (be[0]) led[7:0]  <= wlane[7:0];
            if (be[1]) led[15:8] <= wlane[15:8];
        end
    end

    // A same-cycle pop frees a slot, so a push into a full FIFO is still accepted then.
    assign fifo_full  = (count == DEPTH_C);
    assign fifo_empty = (count == '0);
    assign push       = bus.perip_wen && !dram_hit && word_addr == WA_UDATA;
    assign push_ok    = push && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= bus.perip_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop);
        end
    end

    assign last_tick = (baud_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            state    <= state_nx;
            baud_cnt <= baud_nx;
            bit_idx  <= bit_nx;
            shreg    <= sh_nx;
        end
    end

    always_comb begin
        state_nx = state;
        baud_nx  = baud_cnt + 1'b1;
        bit_nx   = bit_idx;
        sh_nx    = shreg;
        pop      = 1'b0;
        uart_tx  = 1'b1;
        case (state)
            S_IDLE: begin
                baud_nx = '0;
                if (!fifo_empty) begin
                    state_nx = S_START;
                    pop      = 1'b1;
                    sh_nx    = fifo_mem[rd_ptr];
                end
            end
            S_START: begin
                uart_tx = 1'b0;
                if (last_tick) begin
                    state_nx = S_DATA;
                    baud_nx  = '0;
                    bit_nx   = '0;
                end
            end
            S_DATA: begin
                uart_tx = shreg[bit_idx];
                if (last_tick) begin
                    baud_nx = '0;
                    if (bit_idx == 3'd7) state_nx = S_STOP;
                    else                 bit_nx   = bit_idx + 1'b1;
                end
            end
            S_STOP: begin
                if (last_tick) begin
                    baud_nx = '0;
                    // Chain straight into the next start bit so queued frames leave no gap.
                    if (!fifo_empty) begin
                        state_nx = S_START;
                        pop      = 1'b1;
                        sh_nx    = fifo_mem[rd_ptr];
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign dbg_uart_state = state;
    assign stat = {29'h0, fifo_empty, (state != S_IDLE), fifo_full};

    always_comb begin
        rd_nx = 32'h0;
        if (dram_hit) begin
            rd_nx = dram[dram_idx];
        end else begin
            case (word_addr)
                WA_LED:    rd_nx = {16'h0, led};
                WA_UDATA:  rd_nx = stat;
                WA_USTAT:  rd_nx = stat;
                WA_CNT_LO: rd_nx = cnt[31:0];
                WA_CNT_HI: rd_nx = shadow;
                default:   rd_nx = 32'h0;
            endcase
        end
    end

    // Reading CNT_LO snapshots the upper half so a following CNT_HI read is carry-consistent.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.perip_rdata <= 32'h0;
            cnt             <= CNT_INIT;
            shadow          <= 32'h0;
        end else begin
            bus.perip_rdata <= rd_nx;
            cnt             <= cnt + 64'd1;
            if (!bus.perip_wen && !dram_hit && word_addr == WA_CNT_LO) shadow <= cnt[63:32];
        end
    end
endmodule

// File: tb/tb_perip_bridge.sv
// Self-checking bench for perip_bridge: directed bus accesses, rdata scoreboard and UART frame monitor.
module tb_perip_bridge;
    localparam int CLK_DIV = 4;
    localparam logic [63:0] CNT_INIT = 64'h0000_0000_FFFF_FFF0;

    logic        clk;
    logic        rst;
    logic        uart_tx;
    logic [15:0] led;
    logic [1:0]  dbg_uart_state;

    perip_bridge_if bus();

    perip_bridge #(
        .DRAM_AW(10), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(8), .CNT_INIT(CNT_INIT)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .uart_tx(uart_tx), .led(led), .dbg_uart_state(dbg_uart_state)
    );

    int checks = 0;
    int failures = 0;
    int frames_done = 0;
    logic rd_req = 1'b0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [7:0]  tx_q[$];

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%08h exp=%08h", name, act, exp);
        end
    endfunction

    // Driver tasks: inputs change on the falling edge, the DUT samples on the rising edge.
    task automatic idle_cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.perip_wen  = 1'b0;
            bus.perip_addr = 32'h9000_0000;
            bus.perip_mask = 2'b10;
            rd_req         = 1'b0;
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [1:0] mask, input logic [31:0] data);
        @(negedge clk);
        bus.perip_wen   = 1'b1;
        bus.perip_addr  = addr;
        bus.perip_mask  = mask;
        bus.perip_wdata = data;
        rd_req          = 1'b0;
    endtask

    task automatic bus_read(input string name, input logic [31:0] addr, input logic [31:0] exp);
        @(negedge clk);
        bus.perip_wen  = 1'b0;
        bus.perip_addr = addr;
        rd_req         = 1'b1;
        exp_q.push_back(exp);
        tag_q.push_back(name);
    endtask

    task automatic wait_state(input logic [1:0] s, input int max);
        int n = 0;
        while (dbg_uart_state !== s && n < max) begin
            @(negedge clk);
            n++;
        end
        check("wait_uart_state", 32'(n < max), 32'd1);
    endtask

    // rdata scoreboard: a read issued before edge N is compared after edge N.
    initial begin
        logic pend;
        logic [31:0] e;
        string t;
        forever begin
            @(posedge clk);
            pend = rd_req;
            @(negedge clk);
            if (pend) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rdata_unexpected act=%08h exp=none", bus.perip_rdata);
                end else begin
                    e = exp_q.pop_front();
                    t = tag_q.pop_front();
                    if (bus.perip_rdata !== e) begin
                        failures++;
                        $display("FAIL %s act=%08h exp=%08h", t, bus.perip_rdata, e);
                    end
                end
            end
        end
    end

    // UART monitor: every cycle of a frame must match the expected 8N1 waveform.
    initial begin
        logic       in_frame = 1'b0;
        logic       expect_b2b = 1'b0;
        logic [9:0] wave = '0;
        logic [7:0] xb = '0;
        logic [7:0] rx = '0;
        int samp = 0;
        int errs = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame   = 1'b0;
                expect_b2b = 1'b0;
            end else begin
                if (!in_frame) begin
                    if (expect_b2b && uart_tx !== 1'b0) begin
                        checks++;
                        failures++;
                        $display("FAIL uart_gap act=%b exp=0", uart_tx);
                    end
                    expect_b2b = 1'b0;
                    if (uart_tx === 1'b0) begin
                        if (tx_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL uart_unexpected_frame act=start exp=idle");
                            in_frame = 1'b0;
                        end else begin
                            xb       = tx_q.pop_front();
                            wave     = {1'b1, xb, 1'b0};
                            in_frame = 1'b1;
                            samp     = 0;
                            errs     = 0;
                        end
                    end
                end
                if (in_frame) begin
                    if (uart_tx !== wave[samp / CLK_DIV]) errs++;
                    if (samp % CLK_DIV == CLK_DIV / 2 && samp / CLK_DIV >= 1 && samp / CLK_DIV <= 8)
                        rx[samp / CLK_DIV - 1] = uart_tx;
                    samp++;
                    if (samp == 10 * CLK_DIV) begin
                        checks++;
                        frames_done++;
                        if (errs != 0) begin
                            failures++;
                            $display("FAIL uart_frame act=%02h exp=%02h bad_cycles=%0d", rx, xb, errs);
                        end
                        in_frame   = 1'b0;
                        expect_b2b = (tx_q.size() != 0);
                    end
                end
            end
        end
    end

    // Directed sequence
    initial begin
        rst             = 1'b1;
        bus.perip_wen   = 1'b0;
        bus.perip_addr  = 32'h9000_0000;
        bus.perip_mask  = 2'b10;
        bus.perip_wdata = 32'h0;

        repeat (4) @(negedge clk);
        check("rst_rdata", bus.perip_rdata, 32'h0);
        check("rst_led", {16'h0, led}, 32'h0);
        check("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
        check("rst_state", {30'h0, dbg_uart_state}, 32'h0);
        rst = 1'b0;

        // Counter reaches low half 0xFFFF_FFFF fifteen cycles after release.
        idle_cyc(14);
        bus_read("cnt_lo_max", 32'h8020_0020, 32'hFFFF_FFFF);
        bus_read("cnt_hi_precarry", 32'h8020_0024, 32'h0000_0000);
        bus_read("cnt_lo_after", 32'h8020_0020, 32'h0000_0001);
        bus_read("cnt_hi_after", 32'h8020_0024, 32'h0000_0001);
        bus_write(32'h8020_0024, 2'b10, 32'h1234_5678);
        bus_read("cnt_hi_write_ignored", 32'h8020_0024, 32'h0000_0001);
        bus_read("stat_after_reset", 32'h8020_0014, 32'h0000_0004);

        // DRAM byte lanes and boundaries
        bus_write(32'h8010_0000, 2'b10, 32'hDEAD_BEEF);
        bus_write(32'h8010_0002, 2'b00, 32'h0000_0011);
        bus_read("dram_byte_lane", 32'h8010_0000, 32'hDE11_BEEF);
        bus_write(32'h8010_0004, 2'b10, 32'h0000_0000);
        bus_write(32'h8010_0006, 2'b01, 32'h0000_ABCD);
        bus_read("dram_half_hi", 32'h8010_0004, 32'hABCD_0000);
        bus_read("unmapped_read", 32'h8030_0000, 32'h0000_0000);
        bus_write(32'h8010_0005, 2'b01, 32'hFFFF_1234);
        bus_read("dram_half_a0_ignored", 32'h8010_0004, 32'hABCD_1234);
        bus_write(32'h8010_0103, 2'b11, 32'h0BAD_F00D);
        bus_read("dram_mask11_word", 32'h8010_0100, 32'h0BAD_F00D);
        bus_write(32'h8010_0FFC, 2'b10, 32'hCAFE_F00D);
        bus_read("dram_last_word", 32'h8010_0FFC, 32'hCAFE_F00D);
        bus_write(32'h8010_1000, 2'b10, 32'h1234_5678);
        bus_read("dram_past_end", 32'h8010_1000, 32'h0000_0000);
        bus_read("dram_no_alias", 32'h8010_0000, 32'hDE11_BEEF);
        bus_write(32'h8030_0000, 2'b10, 32'hFFFF_FFFF);
        bus_read("unmapped_write", 32'h8030_0000, 32'h0000_0000);

        // LED register
        bus_write(32'h8020_0000, 2'b10, 32'hFFFF_A5C3);
        bus_read("led_word", 32'h8020_0000, 32'h0000_A5C3);
        bus_write(32'h8020_0001, 2'b00, 32'h0000_007E);
        bus_read("led_byte1", 32'h8020_0000, 32'h0000_7EC3);
        bus_write(32'h8020_0002, 2'b00, 32'h0000_0099);
        bus_read("led_byte2_ignored", 32'h8020_0000, 32'h0000_7EC3);
        idle_cyc(1);
        check("led_port", {16'h0, led}, 32'h0000_7EC3);

        // Single UART frame
        tx_q.push_back(8'h55);
        bus_write(32'h8020_0010, 2'b00, 32'h0000_0055);
        idle_cyc(3);
        bus_read("stat_busy", 32'h8020_0014, 32'h0000_0006);
        bus_read("udata_reads_stat", 32'h8020_0010, 32'h0000_0006);
        idle_cyc(45);
        bus_read("stat_idle_after_frame", 32'h8020_0014, 32'h0000_0004);

        // Ten back-to-back pushes: the first is popped at once, eight fill the FIFO, the tenth drops.
        for (int i = 0; i < 10; i++) begin
            if (i < 9) tx_q.push_back(8'hA0 + 8'(i));
            bus_write(32'h8020_0010, 2'b10, 32'h0000_00A0 + i);
        end
        bus_read("stat_full", 32'h8020_0014, 32'h0000_0003);
        idle_cyc(380);
        bus_read("stat_drained", 32'h8020_0014, 32'h0000_0004);
        idle_cyc(2);
        check("frames_done", 32'(frames_done), 32'd10);
        check("tx_queue_drained", 32'(tx_q.size()), 32'd0);

        // Reset in the middle of data bit 3 with bytes still queued
        tx_q.push_back(8'h0F);
        bus_write(32'h8020_0010, 2'b00, 32'h0000_000F);
        bus_write(32'h8020_0010, 2'b00, 32'h0000_0081);
        bus_write(32'h8020_0010, 2'b00, 32'h0000_0042);
        idle_cyc(1);
        wait_state(2'd2, 100);
        idle_cyc(13);
        check("midframe_state", {30'h0, dbg_uart_state}, 32'h2);
        @(negedge clk);
        rst = 1'b1;
        tx_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check("abort_uart_tx", {31'h0, uart_tx}, 32'h1);
        check("abort_led", {16'h0, led}, 32'h0);
        check("abort_state", {30'h0, dbg_uart_state}, 32'h0);
        bus_read("abort_stat", 32'h8020_0014, 32'h0000_0004);
        idle_cyc(200);
        bus_read("stat_quiet", 32'h8020_0014, 32'h0000_0004);
        idle_cyc(3);
        check("frames_after_abort", 32'(frames_done), 32'd10);
        check("reads_answered", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/perip_bridge.md
PERIP_BRIDGE -- requirements
Module: perip_bridge

Interface
REQ-001 Parameter DRAM_AW, default 14, DRAM word-address width (2^DRAM_AW 32-bit words).
REQ-002 Parameter CLK_DIV, default 868, clk cycles per UART bit.
REQ-003 Parameter FIFO_DEPTH, default 8, UART TX FIFO depth in bytes (power of two).
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 perip_addr  in  32  byte address from core.
REQ-007 perip_wen  in  1  write strobe, sampled each cycle.
REQ-008 perip_mask  in  2  write size: 00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-009 perip_wdata  in  32  write data, LSB-aligned for byte/half.
REQ-010 perip_rdata  out  32  read data for address presented previous cycle.
REQ-011 uart_tx  out  1  serial 8N1 output, idle high.
REQ-012 led  out  16  LED register.

Function
REQ-013 Address map: DRAM 0x8010_0000 .. 0x8010_0000+4*2^DRAM_AW-1; LED 0x8020_0000; UART_DATA 0x8020_0010; UART_STAT 0x8020_0014; CNT_LO 0x8020_0020; CNT_HI 0x8020_0024.
REQ-014 Unmapped read returns 0x0000_0000; unmapped write has no effect.
REQ-015 Read latency exactly 1 cycle: perip_rdata registered from address sampled at edge N, valid after edge N; always full 32-bit word at addr[31:2]; core performs extraction.
REQ-016 Writes commit at the edge where perip_wen=1; a read of the same address on the next cycle returns the new value.
REQ-017 Byte lanes: byte -> lane addr[1:0] gets wdata[7:0]; half -> lanes {addr[1],0},{addr[1],1} get wdata[15:0]; word -> all lanes, addr[1:0] ignored; addr[0] ignored for half.
REQ-018 LED: lane-masked write of bits [15:0] only; read returns {16'h0, led}.
REQ-019 UART_DATA write (any mask) pushes wdata[7:0] into FIFO; push while full is dropped; UART_DATA read returns UART_STAT value.
REQ-020 UART_STAT read: bit0 fifo_full, bit1 tx_busy (FSM not IDLE), bit2 fifo_empty, bits[31:3] zero.
REQ-021 UART FSM states IDLE, START, DATA, STOP; IDLE->START when FIFO non-empty, popping head at that edge; START drives 0 for CLK_DIV cycles; DATA drives bits 0..7 LSB first, CLK_DIV cycles each; STOP drives 1 for CLK_DIV cycles; STOP->START directly if FIFO non-empty, else IDLE.
REQ-022 Frame length exactly 10*CLK_DIV cycles; back-to-back frames have no idle gap.
REQ-023 Simultaneous push and pop: both take effect; count unchanged; push into full FIFO with same-cycle pop is accepted.
REQ-024 FIFO pointers wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
REQ-025 64-bit cycle counter increments every non-reset cycle, wraps to 0 after 2^64-1.
REQ-026 CNT_LO read returns counter[31:0] and latches counter[63:32] into shadow in same cycle; CNT_HI read returns shadow; counter writes ignored.

Reset
REQ-027 Under rst: perip_rdata=0, led=0, uart_tx=1, FSM IDLE, FIFO empty, counter=0, shadow=0.
REQ-028 rst mid-frame aborts frame immediately; uart_tx=1 the cycle after reset edge; queued bytes discarded.
REQ-029 DRAM contents not reset.

Verification
REQ-030 Word write 0xDEADBEEF @0x8010_0000, then byte write 0x11 @0x8010_0002 -> read returns 0xDE11BEEF one cycle after address.
REQ-031 Half write 0xABCD @0x8010_0006 over zero word -> read @0x8010_0004 returns 0xABCD_0000; read @0x8030_0000 returns 0.
REQ-032 CLK_DIV=4, write 0x55 to UART_DATA -> uart_tx sequence 0,1,0,1,0,1,0,1,0,1 each 4 cycles, frame 40 cycles, STAT bit1 1 during, 0 after.
REQ-033 FIFO_DEPTH=8, 10 pushes while FSM busy -> STAT bit0=1, 9 bytes transmitted (1 popped + 8 queued), 10th dropped, then STAT=0x4.
REQ-034 Counter preloaded via reset release, read CNT_LO at 0xFFFF_FFFF then CNT_HI -> CNT_HI returns pre-carry value 0, not 1.
REQ-035 Assert rst during DATA bit 3 -> uart_tx=1, STAT=0x4, led=0 next cycle; no further frames.
